// File: rtl/tpu_seq_pkg.sv
// Shared types for the tile sequencer: FSM state encoding, error codes and
// the default watchdog limit.
package tpu_seq_pkg;

  localparam int TIMEOUT_DEFAULT = 1024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DP,
    S_ISSUE,
    S_RUN,
    S_ACT,
    S_DONE,
    S_ERR
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_WAIT = 2'd1,
    ERR_SYS  = 2'd2,
    ERR_VPU  = 2'd3
  } seq_err_t;

endpackage

// File: rtl/seq_watchdog.sv
// Saturating cycle counter; expired is high once LIMIT cycles have elapsed
// since the last clear (the clearing cycle counts as the first).
module seq_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  assign expired = (cnt >= W'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           cnt <= '0;
    else if (clear)    cnt <= '0;
    else if (!expired) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/tile_sequencer.sv
// Runs one matrix tile: wait for datapath idle, launch systolic array + UB
// read, then drain accumulator rows through the VPU back into the UB.
module tile_sequencer
  import tpu_seq_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int UB_AW   = 9,
  parameter int ACC_AW  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [UB_AW-1:0]  cmd_ub_src,
  input  logic [UB_AW-1:0]  cmd_ub_dst,
  input  logic [7:0]        cmd_rows,
  input  logic [ACC_AW-1:0] cmd_acc_addr,
  input  logic [3:0]        cmd_vpu_mode,
  input  logic              cmd_signed,
  input  logic              cmd_acc_clear,
  input  logic              abort,
  input  logic              err_clr,
  input  logic              sys_busy,
  input  logic              sys_done,
  input  logic              vpu_done,
  input  logic              wt_busy,
  input  logic              ub_busy,
  output logic              sys_start,
  output logic [7:0]        sys_rows,
  output logic              sys_signed,
  output logic              sys_acc_clear,
  output logic [ACC_AW-1:0] sys_acc_addr,
  output logic              ub_rd_en,
  output logic              ub_wr_en,
  output logic [UB_AW-1:0]  ub_rd_addr,
  output logic [UB_AW-1:0]  ub_wr_addr,
  output logic [UB_AW-1:0]  ub_rd_count,
  output logic [UB_AW-1:0]  ub_wr_count,
  output logic              acc_rd_en,
  output logic [ACC_AW-1:0] acc_addr,
  output logic              vpu_start,
  output logic [3:0]        vpu_mode,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              seq_err,
  output logic [1:0]        err_code
);

  seq_state_t        state, next_state;
  seq_err_t          err_q;
  logic [UB_AW-1:0]  src_q, dst_q;
  logic [7:0]        rows_q, iss_cnt, cmp_cnt;
  logic [ACC_AW-1:0] acc_q;
  logic [3:0]        mode_q;
  logic              signed_q, clr_q;
  logic              wd_clear, wd_expired, vpu_hit;
  logic              start_d, done_d, issue_fire, wr_fire;

  assign sys_rows      = rows_q;
  assign sys_signed    = signed_q;
  assign sys_acc_clear = clr_q;
  assign sys_acc_addr  = acc_q;
  assign ub_rd_addr    = src_q;
  assign ub_rd_count   = UB_AW'(rows_q);
  assign vpu_mode      = mode_q;
  assign err_code      = err_q;

  // A vpu_done only counts while rows are still owed a write-back.
  assign vpu_hit  = (state == S_ACT) && vpu_done && (cmp_cnt < rows_q);
  assign wd_clear = (next_state != state) || vpu_hit;

  seq_watchdog #(.LIMIT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (cmd_valid) next_state = (cmd_rows == 8'd0) ? S_DONE : S_WAIT_DP;
      S_WAIT_DP: if (!wt_busy && !ub_busy && !sys_busy) next_state = S_ISSUE;
                 else if (wd_expired)                   next_state = S_ERR;
      S_ISSUE:   next_state = S_RUN;
      S_RUN:     if (sys_done)        next_state = S_ACT;
                 else if (wd_expired) next_state = S_ERR;
      S_ACT:     if (vpu_hit && (cmp_cnt == rows_q - 8'd1)) next_state = S_DONE;
                 else if (wd_expired)                       next_state = S_ERR;
      S_DONE:    next_state = S_IDLE;
      S_ERR:     if (err_clr) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
    if (abort && state != S_IDLE && state != S_ERR) next_state = S_IDLE;
  end

  // Strobe d-inputs look at next_state so the strobes themselves are flops.
  always_comb begin
    cmd_ready  = (state == S_IDLE);
    seq_busy   = !(state == S_IDLE || state == S_ERR);
    seq_err    = (state == S_ERR);
    start_d    = (next_state == S_ISSUE);
    done_d     = (next_state == S_DONE);
    issue_fire = (next_state == S_ACT) && (iss_cnt < rows_q);
    wr_fire    = vpu_hit && (next_state == S_ACT || next_state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q <= '0; dst_q <= '0; rows_q <= '0; acc_q <= '0; mode_q <= '0;
      signed_q <= 1'b0; clr_q <= 1'b0;
      iss_cnt <= '0; cmp_cnt <= '0;
      sys_start <= 1'b0; ub_rd_en <= 1'b0; ub_wr_en <= 1'b0;
      acc_rd_en <= 1'b0; vpu_start <= 1'b0; seq_done <= 1'b0;
      acc_addr <= '0; ub_wr_addr <= '0; ub_wr_count <= '0;
      err_q <= ERR_NONE;
    end else begin
      if (state == S_IDLE && cmd_valid) begin
        src_q    <= cmd_ub_src;
        dst_q    <= cmd_ub_dst;
        rows_q   <= cmd_rows;
        acc_q    <= cmd_acc_addr;
        mode_q   <= cmd_vpu_mode;
        signed_q <= cmd_signed;
        clr_q    <= cmd_acc_clear;
        iss_cnt  <= '0;
        cmp_cnt  <= '0;
      end
      sys_start <= start_d;
      ub_rd_en  <= start_d;
      seq_done  <= done_d;
      acc_rd_en <= issue_fire;
      vpu_start <= issue_fire;
      ub_wr_en  <= wr_fire;
      if (issue_fire) begin
        acc_addr <= acc_q + ACC_AW'(iss_cnt);
        iss_cnt  <= iss_cnt + 8'd1;
      end
      if (wr_fire) begin
        ub_wr_addr  <= dst_q + UB_AW'(cmp_cnt);
        ub_wr_count <= UB_AW'(1);
        cmp_cnt     <= cmp_cnt + 8'd1;
      end
      if (next_state == S_ERR && state != S_ERR)
        err_q <= (state == S_WAIT_DP) ? ERR_WAIT :
                 (state == S_RUN)     ? ERR_SYS  : ERR_VPU;
      else if (state == S_ERR && next_state == S_IDLE)
        err_q <= ERR_NONE;
    end
  end

endmodule

// File: tb/tb_tile_sequencer.sv
// Directed bench for tile_sequencer: cycle-indexed stimulus per scenario with
// hand-derived expected strobe timing, addresses and status.
module tb_tile_sequencer;

  localparam int UB_AW = 9;
  localparam int ACC_AW = 8;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready;
  logic [UB_AW-1:0] cmd_ub_src, cmd_ub_dst;
  logic [7:0] cmd_rows;
  logic [ACC_AW-1:0] cmd_acc_addr;
  logic [3:0] cmd_vpu_mode;
  logic cmd_signed, cmd_acc_clear, abort, err_clr;
  logic sys_busy, sys_done, vpu_done, wt_busy, ub_busy;
  logic sys_start, sys_signed, sys_acc_clear;
  logic [7:0] sys_rows;
  logic [ACC_AW-1:0] sys_acc_addr, acc_addr;
  logic ub_rd_en, ub_wr_en, acc_rd_en, vpu_start;
  logic [UB_AW-1:0] ub_rd_addr, ub_wr_addr, ub_rd_count, ub_wr_count;
  logic [3:0] vpu_mode;
  logic seq_busy, seq_done, seq_err;
  logic [1:0] err_code;

  int total = 0;
  int bad = 0;

  tile_sequencer #(.TIMEOUT(16), .UB_AW(UB_AW), .ACC_AW(ACC_AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ub_src(cmd_ub_src), .cmd_ub_dst(cmd_ub_dst), .cmd_rows(cmd_rows),
    .cmd_acc_addr(cmd_acc_addr), .cmd_vpu_mode(cmd_vpu_mode),
    .cmd_signed(cmd_signed), .cmd_acc_clear(cmd_acc_clear),
    .abort(abort), .err_clr(err_clr),
    .sys_busy(sys_busy), .sys_done(sys_done), .vpu_done(vpu_done),
    .wt_busy(wt_busy), .ub_busy(ub_busy),
    .sys_start(sys_start), .sys_rows(sys_rows), .sys_signed(sys_signed),
    .sys_acc_clear(sys_acc_clear), .sys_acc_addr(sys_acc_addr),
    .ub_rd_en(ub_rd_en), .ub_wr_en(ub_wr_en),
    .ub_rd_addr(ub_rd_addr), .ub_wr_addr(ub_wr_addr),
    .ub_rd_count(ub_rd_count), .ub_wr_count(ub_wr_count),
    .acc_rd_en(acc_rd_en), .acc_addr(acc_addr),
    .vpu_start(vpu_start), .vpu_mode(vpu_mode),
    .seq_busy(seq_busy), .seq_done(seq_done), .seq_err(seq_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cmd_valid = 0; cmd_ub_src = '0; cmd_ub_dst = '0; cmd_rows = '0;
    cmd_acc_addr = '0; cmd_vpu_mode = '0; cmd_signed = 0; cmd_acc_clear = 0;
    abort = 0; err_clr = 0;
    sys_busy = 0; sys_done = 0; vpu_done = 0; wt_busy = 0; ub_busy = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL reset.cmd_ready got=%b want=1", cmd_ready);
    end
    total++;
    if ({sys_start, ub_rd_en, ub_wr_en, acc_rd_en, vpu_start, seq_done, seq_busy, seq_err} !== 8'd0) begin
      bad++; $display("FAIL reset.strobes got=%b want=0",
        {sys_start, ub_rd_en, ub_wr_en, acc_rd_en, vpu_start, seq_done, seq_busy, seq_err});
    end
    total++;
    if ({sys_rows, sys_acc_addr, ub_rd_addr, ub_rd_count, ub_wr_addr, ub_wr_count, acc_addr, vpu_mode, err_code,
         sys_signed, sys_acc_clear} !== '0) begin
      bad++; $display("FAIL reset.values got nonzero rows=%h rd=%h wr=%h acc=%h err=%0d",
        sys_rows, ub_rd_addr, ub_wr_addr, acc_addr, err_code);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_nominal();
    logic [7:0] ea;
    logic [8:0] ew;
    clear_inputs();
    cmd_rows = 8'd3; cmd_ub_src = 9'h010; cmd_ub_dst = 9'h120; cmd_acc_addr = 8'hFE;
    cmd_vpu_mode = 4'd1; cmd_signed = 1'b1; cmd_acc_clear = 1'b0;
    for (int c = 0; c <= 14; c++) begin
      cmd_valid = (c == 0);
      sys_done  = (c == 6);
      vpu_done  = (c >= 9 && c <= 11);
      @(negedge clk);
      total++;
      if (sys_start !== (c == 2) || ub_rd_en !== (c == 2)) begin
        bad++; $display("FAIL nominal.start c=%0d got=%b%b want=%b", c, sys_start, ub_rd_en, (c == 2));
      end
      total++;
      if (acc_rd_en !== (c >= 7 && c <= 9) || vpu_start !== (c >= 7 && c <= 9)) begin
        bad++; $display("FAIL nominal.acc_rd c=%0d got=%b%b", c, acc_rd_en, vpu_start);
      end
      if (c >= 7 && c <= 9) begin
        ea = 8'(32'hFE + c - 7);
        total++;
        if (acc_addr !== ea || vpu_mode !== 4'd1) begin
          bad++; $display("FAIL nominal.acc_addr c=%0d got=%h/%0d want=%h/1", c, acc_addr, vpu_mode, ea);
        end
      end
      total++;
      if (ub_wr_en !== (c >= 10 && c <= 12)) begin
        bad++; $display("FAIL nominal.ub_wr_en c=%0d got=%b", c, ub_wr_en);
      end
      if (c >= 10 && c <= 12) begin
        ew = 9'(32'h120 + c - 10);
        total++;
        if (ub_wr_addr !== ew || ub_wr_count !== 9'd1) begin
          bad++; $display("FAIL nominal.ub_wr_addr c=%0d got=%h/%0d want=%h/1", c, ub_wr_addr, ub_wr_count, ew);
        end
      end
      total++;
      if (seq_done !== (c == 12)) begin
        bad++; $display("FAIL nominal.seq_done c=%0d got=%b", c, seq_done);
      end
      total++;
      if (cmd_ready !== (c == 0 || c >= 13)) begin
        bad++; $display("FAIL nominal.cmd_ready c=%0d got=%b", c, cmd_ready);
      end
      if (c == 2) begin
        total++;
        if (ub_rd_addr !== 9'h010 || ub_rd_count !== 9'd3 || sys_rows !== 8'd3 ||
            sys_acc_addr !== 8'hFE || sys_signed !== 1'b1 || sys_acc_clear !== 1'b0) begin
          bad++; $display("FAIL nominal.issue_fields rd=%h cnt=%0d rows=%0d acc=%h s=%b c=%b",
            ub_rd_addr, ub_rd_count, sys_rows, sys_acc_addr, sys_signed, sys_acc_clear);
        end
      end
      step();
    end
  endtask

  task automatic test_busy();
    clear_inputs();
    cmd_rows = 8'd1; cmd_ub_src = 9'h005; cmd_ub_dst = 9'h033; cmd_acc_addr = 8'h10;
    for (int c = 0; c <= 12; c++) begin
      cmd_valid = (c == 0);
      wt_busy   = (c <= 4);
      sys_done  = (c == 8);
      vpu_done  = (c == 10);
      @(negedge clk);
      total++;
      if (sys_start !== (c == 6)) begin
        bad++; $display("FAIL busy.sys_start c=%0d got=%b want=%b", c, sys_start, (c == 6));
      end
      total++;
      if (seq_done !== (c == 11) || ub_wr_en !== (c == 11)) begin
        bad++; $display("FAIL busy.done c=%0d got=%b%b", c, seq_done, ub_wr_en);
      end
      total++;
      if (seq_busy !== (c >= 1 && c <= 11)) begin
        bad++; $display("FAIL busy.seq_busy c=%0d got=%b", c, seq_busy);
      end
      step();
    end
  endtask

  task automatic test_zero_rows();
    clear_inputs();
    cmd_rows = 8'd0; cmd_ub_dst = 9'h055;
    for (int c = 0; c <= 3; c++) begin
      cmd_valid = (c == 0);
      @(negedge clk);
      total++;
      if (seq_done !== (c == 1)) begin
        bad++; $display("FAIL zero.seq_done c=%0d got=%b", c, seq_done);
      end
      total++;
      if ({sys_start, ub_rd_en, ub_wr_en, acc_rd_en, vpu_start} !== 5'd0) begin
        bad++; $display("FAIL zero.strobes c=%0d got=%b want=0", c,
          {sys_start, ub_rd_en, ub_wr_en, acc_rd_en, vpu_start});
      end
      total++;
      if (cmd_ready !== (c != 1)) begin
        bad++; $display("FAIL zero.cmd_ready c=%0d got=%b", c, cmd_ready);
      end
      step();
    end
  endtask

  task automatic test_sys_timeout();
    logic in_err;
    clear_inputs();
    cmd_rows = 8'd2; cmd_ub_src = 9'h0AA;
    for (int c = 0; c <= 25; c++) begin
      cmd_valid = (c == 0) || (c >= 20 && c <= 22);
      err_clr   = (c == 23);
      in_err    = (c >= 19 && c <= 23);
      @(negedge clk);
      total++;
      if (seq_err !== in_err || err_code !== (in_err ? 2'd2 : 2'd0)) begin
        bad++; $display("FAIL timeout.err c=%0d got=%b/%0d want=%b/%0d", c, seq_err, err_code,
          in_err, (in_err ? 2 : 0));
      end
      total++;
      if (cmd_ready !== (c == 0 || c >= 24)) begin
        bad++; $display("FAIL timeout.cmd_ready c=%0d got=%b", c, cmd_ready);
      end
      total++;
      if (seq_busy !== (c >= 1 && c <= 18) || sys_start !== (c == 2)) begin
        bad++; $display("FAIL timeout.busy c=%0d got=%b start=%b", c, seq_busy, sys_start);
      end
      step();
    end
  endtask

  task automatic test_abort();
    clear_inputs();
    cmd_rows = 8'd3; cmd_ub_src = 9'h040; cmd_ub_dst = 9'h0A0; cmd_acc_addr = 8'h20; cmd_vpu_mode = 4'd2;
    for (int c = 0; c <= 14; c++) begin
      cmd_valid = (c == 0);
      sys_done  = (c == 6);
      vpu_done  = (c >= 9 && c <= 11);
      abort     = (c == 10);
      @(negedge clk);
      total++;
      if (ub_wr_en !== (c == 10)) begin
        bad++; $display("FAIL abort.ub_wr_en c=%0d got=%b", c, ub_wr_en);
      end
      total++;
      if (seq_done !== 1'b0) begin
        bad++; $display("FAIL abort.seq_done c=%0d got=%b want=0", c, seq_done);
      end
      total++;
      if (cmd_ready !== (c == 0 || c >= 11)) begin
        bad++; $display("FAIL abort.cmd_ready c=%0d got=%b", c, cmd_ready);
      end
      if (c == 10) begin
        total++;
        if (ub_wr_addr !== 9'h0A0) begin
          bad++; $display("FAIL abort.ub_wr_addr got=%h want=0a0", ub_wr_addr);
        end
      end
      step();
    end
    clear_inputs();
    cmd_rows = 8'd1; cmd_ub_dst = 9'h1F0; cmd_acc_addr = 8'h33;
    for (int c = 0; c <= 9; c++) begin
      cmd_valid = (c == 0);
      sys_done  = (c == 4);
      vpu_done  = (c == 6);
      @(negedge clk);
      total++;
      if (acc_rd_en !== (c == 5) || (c == 5 && acc_addr !== 8'h33)) begin
        bad++; $display("FAIL after_abort.acc c=%0d got=%b/%h", c, acc_rd_en, acc_addr);
      end
      total++;
      if (seq_done !== (c == 7) || ub_wr_en !== (c == 7) || (c == 7 && ub_wr_addr !== 9'h1F0)) begin
        bad++; $display("FAIL after_abort.done c=%0d got=%b%b/%h", c, seq_done, ub_wr_en, ub_wr_addr);
      end
      total++;
      if (cmd_ready !== (c == 0 || c >= 8)) begin
        bad++; $display("FAIL after_abort.cmd_ready c=%0d got=%b", c, cmd_ready);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    clear_inputs();
    cmd_rows = 8'd2; cmd_ub_src = 9'h0C3; cmd_acc_addr = 8'h44; cmd_vpu_mode = 4'd7;
    for (int c = 0; c <= 4; c++) begin
      cmd_valid = (c == 0);
      @(negedge clk);
      if (c == 4) begin
        total++;
        if (seq_busy !== 1'b1 || sys_rows !== 8'd2) begin
          bad++; $display("FAIL areset.pre got busy=%b rows=%0d want 1/2", seq_busy, sys_rows);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (cmd_ready !== 1'b1 || seq_busy !== 1'b0) begin
          bad++; $display("FAIL areset.state got ready=%b busy=%b want 1/0", cmd_ready, seq_busy);
        end
        total++;
        if ({sys_rows, sys_acc_addr, ub_rd_addr, ub_rd_count, ub_wr_addr, ub_wr_count, acc_addr, vpu_mode,
             err_code} !== '0) begin
          bad++; $display("FAIL areset.values got rows=%0d rd=%h acc=%h mode=%0d", sys_rows, ub_rd_addr,
            sys_acc_addr, vpu_mode);
        end
      end else begin
        step();
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_busy();
    test_zero_rows();
    test_sys_timeout();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
